// File: rtl/master_slave7_driver.sv
// master_slave7_driver
// Stimulus-side peer for the master/slave shared-port test design. Drives an
// arithmetic sequence on a data/sync pair, samples the peer's response a fixed
// number of edges after each sync strobe, and counts responses that differ
// from the expected offset. Every output comes straight from a register.

module master_slave7_driver #(
    parameter int unsigned        RESP_LAT   = 1,       // edges from sync edge to sample edge, 1..15
    parameter logic signed [31:0] STEP       = 32'sd1,  // increment between consecutive items
    parameter logic signed [31:0] EXP_OFFSET = 32'sd0   // expected resp_in minus drive_out
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic signed [31:0] seed_i,
    input  logic        [7:0]  count_i,
    input  logic signed [31:0] resp_in_i,
    output logic signed [31:0] drive_out_o,
    output logic               drive_sync_o,
    output logic               busy_o,
    output logic               done_o,
    output logic        [7:0]  err_count_o,
    output logic signed [31:0] last_resp_o
);

    // Section encoding. SECTION_DRIVE is reserved and never entered; the
    // strobe is issued from idle (first item) or from the gap (later items).
    localparam logic [1:0] SECTION_IDLE  = 2'd0;
    localparam logic [1:0] SECTION_DRIVE = 2'd1;
    localparam logic [1:0] SECTION_WAIT  = 2'd2;
    localparam logic [1:0] SECTION_GAP   = 2'd3;

    localparam logic [3:0] LAT_INIT = 4'(RESP_LAT);

    // Saturating 8-bit increment for the mismatch counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

    logic [1:0]         section_q,    section_d;
    logic signed [31:0] value_q,      value_d;
    logic [7:0]         remaining_q,  remaining_d;
    logic [3:0]         wait_q,       wait_d;
    logic signed [31:0] drive_q,      drive_d;
    logic               sync_q,       sync_d;
    logic               busy_q,       busy_d;
    logic               done_q,       done_d;
    logic [7:0]         err_q,        err_d;
    logic signed [31:0] last_q,       last_d;
    logic signed [31:0] expected_s;
    logic               sample_now_s;

    // Next-state logic for the section sequencer and all output registers.
    always_comb begin
        section_d    = section_q;
        value_d      = value_q;
        remaining_d  = remaining_q;
        wait_d       = wait_q;
        drive_d      = drive_q;
        sync_d       = 1'b0;
        busy_d       = busy_q;
        done_d       = 1'b0;
        err_d        = err_q;
        last_d       = last_q;
        // Wrapping 32-bit sum; overflow is intentional.
        expected_s   = drive_q + EXP_OFFSET;
        // The counter reaches zero on this edge when it currently holds 1.
        sample_now_s = (wait_q <= 4'd1);

        case (section_q)
            SECTION_IDLE: begin
                busy_d = 1'b0;
                if (start_i) begin
                    err_d = 8'd0;
                    if (count_i != 8'd0) begin
                        value_d     = seed_i;
                        remaining_d = count_i;
                        drive_d     = seed_i;
                        sync_d      = 1'b1;
                        busy_d      = 1'b1;
                        wait_d      = LAT_INIT;
                        section_d   = SECTION_WAIT;
                    end else begin
                        // Empty run: report completion immediately.
                        done_d = 1'b1;
                    end
                end else begin
                    section_d = SECTION_IDLE;
                end
            end

            SECTION_WAIT: begin
                if (wait_q == 4'd0) begin
                    wait_d = 4'd0;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
                if (sample_now_s) begin
                    last_d = resp_in_i;
                    if (resp_in_i != expected_s) begin
                        err_d = sat_inc8(err_q);
                    end else begin
                        err_d = err_q;
                    end
                    remaining_d = remaining_q - 8'd1;
                    if (remaining_q == 8'd1) begin
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                        section_d = SECTION_IDLE;
                    end else begin
                        value_d   = value_q + STEP;
                        section_d = SECTION_GAP;
                    end
                end else begin
                    section_d = SECTION_WAIT;
                end
            end

            SECTION_GAP: begin
                // One quiet cycle between items keeps sync strobes apart.
                drive_d   = value_q;
                sync_d    = 1'b1;
                wait_d    = LAT_INIT;
                section_d = SECTION_WAIT;
            end

            SECTION_DRIVE: begin
                section_d = SECTION_IDLE;
                busy_d    = 1'b0;
            end

            default: begin
                section_d = SECTION_IDLE;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            section_q   <= SECTION_IDLE;
            value_q     <= 32'sd0;
            remaining_q <= 8'd0;
            wait_q      <= 4'd0;
            drive_q     <= 32'sd0;
            sync_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 8'd0;
            last_q      <= 32'sd0;
        end else begin
            section_q   <= section_d;
            value_q     <= value_d;
            remaining_q <= remaining_d;
            wait_q      <= wait_d;
            drive_q     <= drive_d;
            sync_q      <= sync_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            last_q      <= last_d;
        end
    end

    assign drive_out_o  = drive_q;
    assign drive_sync_o = sync_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_count_o  = err_q;
    assign last_resp_o  = last_q;

endmodule

// File: tb/tb_master_slave7_driver.sv
// Self-checking bench for master_slave7_driver with default parameters.
// The reference model describes each run by cycle index from the start edge:
// item k occupies cycles k*(L+1) .. k*(L+1)+L, its value is seed + k*STEP and
// its response is sampled on the last edge of that window.

module tb_master_slave7_driver;

    localparam int          L      = 1;
    localparam logic [31:0] STEP_C = 32'd1;
    localparam logic [31:0] OFFS_C = 32'd0;

    logic               clk_i = 1'b0;
    logic               rst_ni;
    logic               start_i;
    logic signed [31:0] seed_i;
    logic        [7:0]  count_i;
    logic signed [31:0] resp_in_i;
    logic signed [31:0] drive_out_o;
    logic               drive_sync_o;
    logic               busy_o;
    logic               done_o;
    logic        [7:0]  err_count_o;
    logic signed [31:0] last_resp_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_drive;
    logic [31:0] exp_last;
    logic [31:0] val_tab  [256];
    logic [31:0] resp_tab [256];

    master_slave7_driver dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .seed_i       (seed_i),
        .count_i      (count_i),
        .resp_in_i    (resp_in_i),
        .drive_out_o  (drive_out_o),
        .drive_sync_o (drive_sync_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_count_o  (err_count_o),
        .last_resp_o  (last_resp_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_outputs(input string tag, input logic sync_e, input logic busy_e,
                                 input logic done_e, input logic [31:0] err_e);
        check({tag, ".drive_sync"}, 32'(drive_sync_o), 32'(sync_e));
        check({tag, ".busy"},       32'(busy_o),       32'(busy_e));
        check({tag, ".done"},       32'(done_o),       32'(done_e));
        check({tag, ".drive_out"},  drive_out_o,       exp_drive);
        check({tag, ".err_count"},  32'(err_count_o),  err_e);
        check({tag, ".last_resp"},  last_resp_o,       exp_last);
    endtask

    // mode: 0 echo, 1 random mismatches, 2 every item mismatches, 3 item 2 returns 99
    // abort_at: cycle index at which reset is asserted (-1 for none)
    task automatic do_run(input string tag, input logic [31:0] s, input int n,
                          input int mode, input int abort_at);
        int          total;
        int          errs;
        int          k;
        int          p;
        logic [31:0] good;
        for (int i = 0; i < n; i++) begin
            val_tab[i] = s + STEP_C * 32'(i);
            good = val_tab[i] + OFFS_C;
            case (mode)
                1:       resp_tab[i] = ($urandom_range(0, 2) == 0) ? (good ^ ($urandom | 32'd1)) : good;
                2:       resp_tab[i] = good + 32'd1;
                3:       resp_tab[i] = (i == 1) ? 32'd99 : good;
                default: resp_tab[i] = good;
            endcase
        end
        resp_in_i = resp_tab[0];
        start_i   = 1'b1;
        seed_i    = s;
        count_i   = 8'(n);
        tick();
        start_i = 1'b0;
        total   = n * (L + 1);
        errs    = 0;
        for (int c = 0; c < total; c++) begin
            k = c / (L + 1);
            p = c % (L + 1);
            if (p == 0) exp_drive = val_tab[k];
            if (p == L) begin
                exp_last = resp_tab[k];
                if (resp_tab[k] !== val_tab[k] + OFFS_C && errs < 255) errs++;
            end
            check_outputs(tag, p == 0, c < total - 1, c == total - 1, 32'(errs));
            if (c == abort_at) begin
                start_i = 1'b0;
                rst_ni  = 1'b0;
                #1;
                exp_drive = 32'd0;
                exp_last  = 32'd0;
                check_outputs({tag, ".in_reset"}, 1'b0, 1'b0, 1'b0, 32'd0);
                tick();
                tick();
                @(negedge clk_i);
                rst_ni = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    tick();
                    check_outputs({tag, ".after_reset"}, 1'b0, 1'b0, 1'b0, 32'd0);
                end
                break;
            end
            if (c < total - 1) begin
                // Peer answer for the next edge; seed/count/start noise must be ignored.
                resp_in_i = resp_tab[(c + 1) / (L + 1)];
                seed_i    = $urandom;
                count_i   = 8'($urandom);
                start_i   = ($urandom_range(0, 5) == 0) || (c == 1);
                tick();
                start_i   = 1'b0;
            end
        end
    endtask

    initial begin
        rst_ni    = 1'b0;
        start_i   = 1'b0;
        seed_i    = 32'sd0;
        count_i   = 8'd0;
        resp_in_i = 32'sd0;
        exp_drive = 32'd0;
        exp_last  = 32'd0;
        #1;
        check_outputs("reset", 1'b0, 1'b0, 1'b0, 32'd0);
        tick();
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        check_outputs("idle", 1'b0, 1'b0, 1'b0, 32'd0);

        // Echo peer, seed 5, three items: 5,6,7, done at E0+5, last_resp 7.
        do_run("echo", 32'd5, 3, 0, -1);
        check("echo.final_last", last_resp_o, 32'd7);

        // Same run, peer answers 99 on the second item.
        do_run("bad_item2", 32'd5, 3, 3, -1);
        check("bad_item2.err", 32'(err_count_o), 32'd1);

        // Empty run: one done pulse, nothing driven, err cleared.
        start_i = 1'b1;
        count_i = 8'd0;
        seed_i  = 32'sd123;
        tick();
        start_i = 1'b0;
        check_outputs("count0", 1'b0, 1'b0, 1'b1, 32'd0);
        tick();
        check_outputs("count0.after", 1'b0, 1'b0, 1'b0, 32'd0);

        // Wrap of the driven value.
        do_run("wrap", 32'h7FFF_FFFF, 2, 0, -1);
        check("wrap.second", drive_out_o, 32'h8000_0000);

        // Randomised runs against the model.
        for (int r = 0; r < 8; r++) begin
            do_run("rand", $urandom, $urandom_range(1, 20), 1, -1);
        end

        // Saturation runs: 255 mismatches, then a fresh run restarts at 0.
        do_run("sat1", $urandom, 255, 2, -1);
        check("sat1.err", 32'(err_count_o), 32'd255);
        do_run("sat2", $urandom, 255, 2, -1);
        check("sat2.err", 32'(err_count_o), 32'd255);

        // Reset during the second item's wait window.
        do_run("abort", $urandom, 5, 2, L + 1);

        // Recovery after reset.
        do_run("recover", $urandom, 4, 1, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
